// File: rtl/mem_interface_unit.sv
// Memory interface stage behind the microprogrammed control unit.
// Runs one multi-cycle access to a byte-addressable big-endian RAM and signals completion on MOC
// using a 4-phase handshake with MemEn.
// The optional alignment check is enabled by defining MEM_ALIGN_CHECK_EN. With it enabled,
// misaligned word/halfword accesses are skipped and flagged on AlignErr. Without it, the low
// address bits are forced to zero.

module mem_interface_unit #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MemEn,
    input  logic              RW,
    input  logic [1:0]        DataType,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              AlignErr
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [1:0]      dtype_q, dtype_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     dout_q, dout_d;
    logic            moc_q, moc_d;
    logic            align_err_q, align_err_d;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   lane_addr [4];
    logic [7:0]      rbyte [4];
    logic [7:0]      wbyte [4];
    logic [3:0]      we;
    logic [31:0]     rdata;
    logic [AW-1:0]   req_addr;
    logic            misaligned;
    logic            exec;
    logic            access_ok;

    // Upper MAR bits beyond the RAM size are intentionally ignored (address wraps).
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[ADDR_W-1:AW];

`ifdef MEM_ALIGN_CHECK_EN
    // Keep the raw address; misalignment is judged on the latched request.
    always_comb begin
        req_addr   = Address[AW-1:0];
        misaligned = ((dtype_q == 2'b00) && (addr_q[1:0] != 2'b00)) ||
                     ((dtype_q == 2'b10) && addr_q[0]);
    end
`else
    // Force natural alignment by clearing the low address bits.
    always_comb begin
        req_addr   = Address[AW-1:0];
        misaligned = 1'b0;
        if (DataType == 2'b00) begin
            req_addr[1:0] = 2'b00;
        end else if (DataType == 2'b10) begin
            req_addr[0] = 1'b0;
        end
    end
`endif

    assign exec      = (state_q == StBusy) && (cnt_q == '0);
    assign access_ok = exec && !misaligned;

    // Byte lane addresses, wrapping at the top of RAM, and the bytes stored there.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr_q + AW'(k);
            rbyte[k]     = mem[lane_addr[k]];
        end
    end

    // Assemble big-endian read data according to the latched data type.
    always_comb begin
        rdata = 32'h0;
        unique case (dtype_q)
            2'b00: rdata = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
            2'b01: rdata = {24'h0, rbyte[0]};
            2'b10: rdata = {16'h0, rbyte[0], rbyte[1]};
            2'b11: rdata = {{24{rbyte[0][7]}}, rbyte[0]};
            default: rdata = 32'h0;
        endcase
    end

    // Per-lane write enables and data; sign-extend byte type writes like a plain byte.
    always_comb begin
        we = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wbyte[k] = 8'h00;
        end
        if (access_ok && !rw_q) begin
            unique case (dtype_q)
                2'b00: begin
                    we       = 4'b1111;
                    wbyte[0] = wdata_q[31:24];
                    wbyte[1] = wdata_q[23:16];
                    wbyte[2] = wdata_q[15:8];
                    wbyte[3] = wdata_q[7:0];
                end
                2'b10: begin
                    we       = 4'b0011;
                    wbyte[0] = wdata_q[15:8];
                    wbyte[1] = wdata_q[7:0];
                end
                default: begin
                    we       = 4'b0001;
                    wbyte[0] = wdata_q[7:0];
                end
            endcase
        end
    end

    // RAM storage; never cleared by reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
                mem[lane_addr[k]] <= wbyte[k];
            end
        end
    end

    // Next-state logic for the IDLE -> BUSY -> DONE handshake sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        dtype_d     = dtype_q;
        wdata_d     = wdata_q;
        dout_d      = dout_q;
        moc_d       = moc_q;
        align_err_d = align_err_q;
        unique case (state_q)
            StIdle: begin
                if (MemEn) begin
                    addr_d  = req_addr;
                    rw_d    = RW;
                    dtype_d = DataType;
                    wdata_d = DataIn;
                    cnt_d   = CW'(WAIT_CYCLES - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d     = StDone;
                    moc_d       = 1'b1;
                    align_err_d = misaligned;
                    if (access_ok && rw_q) begin
                        dout_d = rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (!MemEn) begin
                    state_d     = StIdle;
                    moc_d       = 1'b0;
                    align_err_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            dtype_q     <= 2'b00;
            wdata_q     <= 32'h0;
            dout_q      <= 32'h0;
            moc_q       <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            dtype_q     <= dtype_d;
            wdata_q     <= wdata_d;
            dout_q      <= dout_d;
            moc_q       <= moc_d;
            align_err_q <= align_err_d;
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign AlignErr = align_err_q;
`else
    logic unused_align;
    assign unused_align = align_err_q ^ align_err_d;
`endif

endmodule

// File: tb/tb_mem_interface_unit.sv
// Self-checking bench for mem_interface_unit with a byte-array reference model of the RAM.
// It also covers the MEM_ALIGN_CHECK_EN build when that macro is defined.

module tb_mem_interface_unit;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DEPTH       = 512;
    localparam int unsigned WAIT_CYCLES = 2;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        MemEn    = 1'b0;
    logic        RW       = 1'b0;
    logic [1:0]  DataType = 2'b00;
    logic [31:0] Address  = 32'h0;
    logic [31:0] DataIn   = 32'h0;
    logic [31:0] DataOut;
    logic        MOC;
`ifdef MEM_ALIGN_CHECK_EN
    logic        AlignErr;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: RAM bytes, expected DataOut, expected alignment flag.
    logic [7:0]  mm [DEPTH];
    logic [31:0] exp_dout = 32'h0;
    logic        exp_ae   = 1'b0;

    always #5 clk = ~clk;

    mem_interface_unit #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .MemEn    (MemEn),
        .RW       (RW),
        .DataType (DataType),
        .Address  (Address),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .MOC      (MOC)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .AlignErr (AlignErr)
`endif
    );

    function automatic bit is_misaligned(input logic [31:0] addr, input logic [1:0] dt);
`ifdef MEM_ALIGN_CHECK_EN
        return ((dt == 2'b00) && (addr[1:0] != 2'b00)) || ((dt == 2'b10) && addr[0]);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned eff_addr(input logic [31:0] addr, input logic [1:0] dt);
        int unsigned a;
        a = addr % DEPTH;
`ifndef MEM_ALIGN_CHECK_EN
        if (dt == 2'b00) a = a - (a % 4);
        else if (dt == 2'b10) a = a - (a % 2);
`endif
        return a;
    endfunction

    // Applies one access to the model, following the big-endian rules.
    task automatic model_access(input bit rw, input logic [1:0] dt, input logic [31:0] addr,
                                input logic [31:0] din);
        int unsigned a;
        logic [7:0] b [4];
        exp_ae = is_misaligned(addr, dt);
        if (exp_ae) return;
        a = eff_addr(addr, dt);
        for (int i = 0; i < 4; i++) b[i] = mm[(a + i) % DEPTH];
        if (rw) begin
            case (dt)
                2'b00: exp_dout = {b[0], b[1], b[2], b[3]};
                2'b01: exp_dout = {24'h0, b[0]};
                2'b10: exp_dout = {16'h0, b[0], b[1]};
                default: exp_dout = {{24{b[0][7]}}, b[0]};
            endcase
        end else begin
            case (dt)
                2'b00: for (int i = 0; i < 4; i++) mm[(a + i) % DEPTH] = din[31-8*i -: 8];
                2'b10: begin
                    mm[a] = din[15:8];
                    mm[(a + 1) % DEPTH] = din[7:0];
                end
                default: mm[a] = din[7:0];
            endcase
        end
    endtask

    task automatic start_req(input bit rw, input logic [1:0] dt, input logic [31:0] addr,
                             input logic [31:0] din);
        @(negedge clk);
        MemEn = 1'b1; RW = rw; DataType = dt; Address = addr; DataIn = din;
    endtask

    // Counts edges (from the request edge) until MOC is seen high, bounded.
    task automatic wait_moc(input int lat0, output int lat);
        lat = lat0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (MOC !== 1'b1 && lat < 20);
    endtask

    task automatic end_req;
        @(negedge clk);
        MemEn = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #12;
        checks++;
        if (MOC !== 1'b0) begin errors++; $display("FAIL reset_moc got=%b want=0", MOC); end
        checks++;
        if (DataOut !== 32'h0) begin
            errors++; $display("FAIL reset_dout got=%h want=00000000", DataOut);
        end
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (AlignErr !== 1'b0) begin errors++; $display("FAIL reset_ae got=%b want=0", AlignErr); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Fill RAM so every model byte is known.
    task automatic init_ram;
        int lat;
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i += 4) begin
            d = $urandom();
            start_req(1'b0, 2'b00, i, d);
            wait_moc(0, lat);
            model_access(1'b0, 2'b00, i, d);
            end_req();
        end
    endtask

    task automatic test_word_write;
        logic exp_moc;
        start_req(1'b0, 2'b00, 32'h10, 32'hDEADBEEF);
        for (int e = 1; e <= WAIT_CYCLES + 1; e++) begin
            @(posedge clk); #1;
            exp_moc = (e == WAIT_CYCLES + 1);
            checks++;
            if (MOC !== exp_moc) begin
                errors++; $display("FAIL ww_moc_edge%0d got=%b want=%b", e, MOC, exp_moc);
            end
        end
        model_access(1'b0, 2'b00, 32'h10, 32'hDEADBEEF);
        @(posedge clk); #1;
        checks++;
        if (MOC !== 1'b1) begin errors++; $display("FAIL ww_moc_hold got=%b want=1", MOC); end
        end_req();
        checks++;
        if (MOC !== 1'b0) begin errors++; $display("FAIL ww_moc_drop got=%b want=0", MOC); end
    endtask

    task automatic test_readback;
        int lat;
        logic [1:0]  dts [4]  = '{2'b00, 2'b01, 2'b11, 2'b10};
        logic [31:0] adrs [4] = '{32'h10, 32'h11, 32'h11, 32'h12};
        logic [31:0] want [4] = '{32'hDEADBEEF, 32'h000000AD, 32'hFFFFFFAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            start_req(1'b1, dts[i], adrs[i], $urandom());
            wait_moc(0, lat);
            model_access(1'b1, dts[i], adrs[i], 32'h0);
            checks++;
            if (DataOut !== want[i]) begin
                errors++; $display("FAIL readback%0d got=%h want=%h", i, DataOut, want[i]);
            end
            checks++;
            if (lat !== WAIT_CYCLES + 1) begin
                errors++; $display("FAIL readback%0d_lat got=%0d want=%0d", i, lat, WAIT_CYCLES + 1);
            end
            end_req();
        end
    endtask

    task automatic test_byte_write_pulse;
        int lat;
        logic exp_moc;
        start_req(1'b0, 2'b01, 32'h13, 32'h1234565A);
        @(posedge clk); #1;
        @(negedge clk);
        MemEn = 1'b0;
        for (int e = 2; e <= WAIT_CYCLES + 2; e++) begin
            @(posedge clk); #1;
            exp_moc = (e == WAIT_CYCLES + 1);
            checks++;
            if (MOC !== exp_moc) begin
                errors++; $display("FAIL pulse_moc_edge%0d got=%b want=%b", e, MOC, exp_moc);
            end
        end
        model_access(1'b0, 2'b01, 32'h13, 32'h1234565A);
        start_req(1'b1, 2'b00, 32'h10, 32'h0);
        wait_moc(0, lat);
        model_access(1'b1, 2'b00, 32'h10, 32'h0);
        checks++;
        if (DataOut !== 32'hDEADBE5A) begin
            errors++; $display("FAIL byte_merge got=%h want=deadbe5a", DataOut);
        end
        end_req();
    endtask

    // One checked access against the model: latency, DataOut, alignment flag, MOC drop.
    task automatic checked_access(input string nm, input bit rw, input logic [1:0] dt,
                                  input logic [31:0] addr, input logic [31:0] din);
        int lat;
        start_req(rw, dt, addr, din);
        wait_moc(0, lat);
        model_access(rw, dt, addr, din);
        checks++;
        if (lat !== WAIT_CYCLES + 1) begin
            errors++; $display("FAIL %s_lat got=%0d want=%0d", nm, lat, WAIT_CYCLES + 1);
        end
        checks++;
        if (DataOut !== exp_dout) begin
            errors++; $display("FAIL %s_dout got=%h want=%h", nm, DataOut, exp_dout);
        end
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (AlignErr !== exp_ae) begin
            errors++; $display("FAIL %s_ae got=%b want=%b", nm, AlignErr, exp_ae);
        end
`endif
        end_req();
        checks++;
        if (MOC !== 1'b0) begin errors++; $display("FAIL %s_drop got=%b want=0", nm, MOC); end
    endtask

    task automatic test_wrap;
        checked_access("wrap_wr", 1'b0, 2'b00, DEPTH - 2, 32'h01020304);
        checked_access("wrap_rd0", 1'b1, 2'b00, 32'h0, 32'h0);
        checked_access("wrap_rdtop", 1'b1, 2'b00, DEPTH - 4, 32'h0);
        checked_access("wrap_hw_rd", 1'b1, 2'b10, DEPTH - 2, 32'h0);
    endtask

    task automatic test_busy_ignore;
        int lat;
        start_req(1'b1, 2'b00, 32'h20, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        RW = 1'b0; Address = 32'h30; DataIn = 32'hA5A5A5A5; DataType = 2'b01;
        wait_moc(1, lat);
        model_access(1'b1, 2'b00, 32'h20, 32'h0);
        checks++;
        if (DataOut !== exp_dout) begin
            errors++; $display("FAIL busy_ignore_dout got=%h want=%h", DataOut, exp_dout);
        end
        end_req();
        checked_access("busy_ignore_mem", 1'b1, 2'b00, 32'h30, 32'h0);
    endtask

    task automatic test_reset_mid_busy;
        start_req(1'b0, 2'b00, 32'h40, 32'hCAFEF00D);
        @(posedge clk); #1;
        @(negedge clk);
        reset_n = 1'b0;
        MemEn   = 1'b0;
        #1;
        exp_dout = 32'h0;
        checks++;
        if (MOC !== 1'b0) begin errors++; $display("FAIL rst_busy_moc got=%b want=0", MOC); end
        checks++;
        if (DataOut !== 32'h0) begin
            errors++; $display("FAIL rst_busy_dout got=%h want=00000000", DataOut);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        checked_access("rst_busy_mem", 1'b1, 2'b00, 32'h40, 32'h0);
    endtask

    task automatic test_align;
        checked_access("align_word", 1'b1, 2'b00, 32'h11, 32'h0);
        checked_access("align_half", 1'b1, 2'b10, 32'h13, 32'h0);
        checked_access("align_hw_wr", 1'b0, 2'b10, 32'h21, 32'h0000BBCC);
        checked_access("align_chk", 1'b1, 2'b00, 32'h20, 32'h0);
    endtask

    task automatic test_random;
        bit rw;
        logic [1:0] dt;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            rw   = 1'($urandom_range(0, 1));
            dt   = 2'($urandom_range(0, 3));
            addr = $urandom();
            checked_access($sformatf("rand%0d", i), rw, dt, addr, $urandom());
        end
    endtask

    initial begin
        test_reset();
        init_ram();
        test_word_write();
        test_readback();
        test_byte_write_pulse();
        test_align();
        test_wrap();
        test_busy_ignore();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
